// File: rtl/mod_148_4_4_timer.sv
// Five independent PLCA down-counting timers (to, beacon, beacon_det, invalid_beacon, burst),
// each stepping IDLE -> RUNNING -> EXPIRED on bit_tick; status is decoded straight from state flops.
package mod_148_4_4_timer_pkg;
  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUNNING = 2'd1,
    T_EXPIRED = 2'd2
  } tstate_e;
endpackage

// Single timer: start loads the duration (0 expires at once), tick decrements, stop returns to IDLE.
// Start has priority over stop and over a same-cycle tick.
module mod_148_4_4_timer_unit
  import mod_148_4_4_timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_tick,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic [W-1:0] i_dur,
  output tstate_e      o_state
);
  localparam logic [W-1:0] L_ONE = W'(1);

  tstate_e      r_state;
  tstate_e      w_state_nxt;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= T_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_start) begin
      w_cnt_nxt   = i_dur;
      w_state_nxt = (i_dur == '0) ? T_EXPIRED : T_RUNNING;
    end else if (i_stop) begin
      w_cnt_nxt   = '0;
      w_state_nxt = T_IDLE;
    end else if ((r_state == T_RUNNING) && i_tick) begin
      // <= 1 rather than == 1 so the counter can never step below zero
      if (r_cnt <= L_ONE) begin
        w_cnt_nxt   = '0;
        w_state_nxt = T_EXPIRED;
      end else begin
        w_cnt_nxt = r_cnt - L_ONE;
      end
    end
  end

  assign o_state = r_state;
endmodule

module mod_148_4_4_timer
  import mod_148_4_4_timer_pkg::*;
#(
  parameter int BEACON_TIMER         = 20,
  parameter int BEACON_DET_TIMER     = 22,
  parameter int INVALID_BEACON_TIMER = 4000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bit_tick,
  input  logic [7:0] plca_to_timer,
  input  logic [7:0] plca_burst_timer,
  input  logic       to_timer_start,
  input  logic       to_timer_stop,
  input  logic       beacon_timer_start,
  input  logic       beacon_det_timer_start,
  input  logic       invalid_beacon_timer_start,
  input  logic       burst_timer_start,
  output logic       to_timer_done,
  output logic       to_timer_not_done,
  output logic       beacon_timer_done,
  output logic       beacon_det_timer_done,
  output logic       beacon_det_timer_not_done,
  output logic       invalid_beacon_timer_done,
  output logic       burst_timer_done
);
  localparam logic [4:0]  L_BCN_DUR = 5'(BEACON_TIMER);
  localparam logic [4:0]  L_DET_DUR = 5'(BEACON_DET_TIMER);
  localparam logic [12:0] L_INV_DUR = 13'(INVALID_BEACON_TIMER);

  tstate_e w_to_state;
  tstate_e w_bcn_state;
  tstate_e w_det_state;
  tstate_e w_inv_state;
  tstate_e w_burst_state;

  mod_148_4_4_timer_unit #(.W(8)) u_to (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tick  (bit_tick),
    .i_start (to_timer_start),
    .i_stop  (to_timer_stop),
    .i_dur   (plca_to_timer),
    .o_state (w_to_state)
  );

  mod_148_4_4_timer_unit #(.W(5)) u_beacon (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tick  (bit_tick),
    .i_start (beacon_timer_start),
    .i_stop  (1'b0),
    .i_dur   (L_BCN_DUR),
    .o_state (w_bcn_state)
  );

  mod_148_4_4_timer_unit #(.W(5)) u_beacon_det (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tick  (bit_tick),
    .i_start (beacon_det_timer_start),
    .i_stop  (1'b0),
    .i_dur   (L_DET_DUR),
    .o_state (w_det_state)
  );

  mod_148_4_4_timer_unit #(.W(13)) u_invalid_beacon (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tick  (bit_tick),
    .i_start (invalid_beacon_timer_start),
    .i_stop  (1'b0),
    .i_dur   (L_INV_DUR),
    .o_state (w_inv_state)
  );

  mod_148_4_4_timer_unit #(.W(8)) u_burst (
    .clk     (clk),
    .reset_n (reset_n),
    .i_tick  (bit_tick),
    .i_start (burst_timer_start),
    .i_stop  (1'b0),
    .i_dur   (plca_burst_timer),
    .o_state (w_burst_state)
  );

  assign to_timer_done             = (w_to_state == T_EXPIRED);
  assign to_timer_not_done         = (w_to_state == T_RUNNING);
  assign beacon_timer_done         = (w_bcn_state == T_EXPIRED);
  assign beacon_det_timer_done     = (w_det_state == T_EXPIRED);
  assign beacon_det_timer_not_done = (w_det_state == T_RUNNING);
  assign invalid_beacon_timer_done = (w_inv_state == T_EXPIRED);
  assign burst_timer_done          = (w_burst_state == T_EXPIRED);
endmodule

// File: tb/tb_mod_148_4_4_timer.sv
// Randomized and directed bench for the PLCA timer block; expected status per cycle comes from a
// start/tick-count model and is queued for a separate monitor that compares after each edge.
module tb_mod_148_4_4_timer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       bit_tick = 1'b0;
  logic [7:0] plca_to_timer = '0;
  logic [7:0] plca_burst_timer = '0;
  logic       to_timer_start = 1'b0;
  logic       to_timer_stop = 1'b0;
  logic       beacon_timer_start = 1'b0;
  logic       beacon_det_timer_start = 1'b0;
  logic       invalid_beacon_timer_start = 1'b0;
  logic       burst_timer_start = 1'b0;
  logic       to_timer_done, to_timer_not_done, beacon_timer_done;
  logic       beacon_det_timer_done, beacon_det_timer_not_done;
  logic       invalid_beacon_timer_done, burst_timer_done;
  logic [6:0] w_out;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [6:0] exp_q[$];

  // Model: a started timer counts ticks seen since its start; done once ticks reach the duration.
  bit m_act[5];
  int m_dur[5];
  int m_ticks[5];

  mod_148_4_4_timer dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .bit_tick                   (bit_tick),
    .plca_to_timer              (plca_to_timer),
    .plca_burst_timer           (plca_burst_timer),
    .to_timer_start             (to_timer_start),
    .to_timer_stop              (to_timer_stop),
    .beacon_timer_start         (beacon_timer_start),
    .beacon_det_timer_start     (beacon_det_timer_start),
    .invalid_beacon_timer_start (invalid_beacon_timer_start),
    .burst_timer_start          (burst_timer_start),
    .to_timer_done              (to_timer_done),
    .to_timer_not_done          (to_timer_not_done),
    .beacon_timer_done          (beacon_timer_done),
    .beacon_det_timer_done      (beacon_det_timer_done),
    .beacon_det_timer_not_done  (beacon_det_timer_not_done),
    .invalid_beacon_timer_done  (invalid_beacon_timer_done),
    .burst_timer_done           (burst_timer_done)
  );

  assign w_out = {to_timer_done, to_timer_not_done, beacon_timer_done, beacon_det_timer_done,
                  beacon_det_timer_not_done, invalid_beacon_timer_done, burst_timer_done};

  always #5 clk = ~clk;

  function automatic logic [6:0] model_out();
    logic [4:0] d;
    logic [4:0] nd;
    for (int i = 0; i < 5; i++) begin
      d[i]  = m_act[i] && (m_ticks[i] >= m_dur[i]);
      nd[i] = m_act[i] && (m_ticks[i] < m_dur[i]);
    end
    return {d[0], nd[0], d[1], d[2], nd[2], d[3], d[4]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      m_act[i]   = 1'b0;
      m_dur[i]   = 0;
      m_ticks[i] = 0;
    end
  endtask

  // st bits: 0 to, 1 beacon, 2 beacon_det, 3 invalid_beacon, 4 burst
  task automatic step(input logic [4:0] st, input logic stp, input logic tk,
                      input logic [7:0] td, input logic [7:0] bd);
    @(negedge clk);
    cyc++;
    to_timer_start             = st[0];
    beacon_timer_start         = st[1];
    beacon_det_timer_start     = st[2];
    invalid_beacon_timer_start = st[3];
    burst_timer_start          = st[4];
    to_timer_stop              = stp;
    bit_tick                   = tk;
    plca_to_timer              = td;
    plca_burst_timer           = bd;
    if (reset_n) begin
      for (int i = 0; i < 5; i++) begin
        if (st[i]) begin
          m_act[i]   = 1'b1;
          m_ticks[i] = 0;
          case (i)
            0:       m_dur[i] = int'(td);
            1:       m_dur[i] = 20;
            2:       m_dur[i] = 22;
            3:       m_dur[i] = 4000;
            default: m_dur[i] = int'(bd);
          endcase
        end else if (i == 0 && stp) begin
          m_act[i] = 1'b0;
        end else if (m_act[i] && tk && m_ticks[i] < m_dur[i]) begin
          m_ticks[i]++;
        end
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle_ticks(input int n, input logic tk);
    for (int k = 0; k < n; k++)
      step(5'b0, 1'b0, tk, 8'($urandom), 8'($urandom));
  endtask

  task automatic check_zero(input string name);
    compared++;
    if (w_out !== 7'b0) begin
      mismatched++;
      $display("FAIL %s: outputs got %b, expected 0000000", name, w_out);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_zero("async_reset");
    model_clear();
    for (int k = 0; k < n; k++)
      step(5'($urandom), 1'($urandom), 1'b1, 8'($urandom), 8'($urandom));
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  // Monitor: outputs are stable 2 time units after each active edge.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (w_out !== e) begin
          mismatched++;
          $display("FAIL status cyc%0d: outputs got %b, expected %b", cyc, w_out, e);
        end
      end
    end
  end

  initial begin
    model_clear();
    #2 reset_n = 1'b0;
    #1 check_zero("reset_state");
    for (int k = 0; k < 3; k++)
      step(5'b11111, 1'b0, 1'b1, 8'd3, 8'd3);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // to_timer = 32, tick every cycle
    step(5'b00001, 1'b0, 1'b1, 8'd32, 8'd0);
    idle_ticks(40, 1'b1);

    // beacon with a tick every 4th cycle
    step(5'b00010, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int k = 1; k <= 90; k++)
      step(5'b0, 1'b0, (k % 4) == 0, 8'($urandom), 8'($urandom));

    // to_timer stopped at count 10, later ticks ignored
    step(5'b00001, 1'b0, 1'b1, 8'd20, 8'd0);
    idle_ticks(10, 1'b1);
    step(5'b0, 1'b1, 1'b1, 8'd0, 8'd0);
    idle_ticks(25, 1'b1);
    step(5'b0, 1'b1, 1'b1, 8'd0, 8'd0);
    idle_ticks(2, 1'b1);

    // burst 0 expires with no tick, then restart with 5 (start-cycle tick ignored)
    step(5'b10000, 1'b0, 1'b0, 8'd0, 8'd0);
    idle_ticks(3, 1'b0);
    step(5'b10000, 1'b0, 1'b1, 8'd0, 8'd5);
    idle_ticks(8, 1'b1);

    // start and stop together: start wins
    step(5'b00001, 1'b1, 1'b1, 8'd8, 8'd0);
    idle_ticks(12, 1'b1);

    // all timers started in the same cycle
    step(5'b11111, 1'b0, 1'b0, 8'd3, 8'd4);
    idle_ticks(30, 1'b1);

    // invalid_beacon run 3000 ticks then reset; must never expire afterwards
    step(5'b01000, 1'b0, 1'b1, 8'd0, 8'd0);
    idle_ticks(3000, 1'b1);
    do_reset(2);
    for (int k = 0; k < 4100; k++)
      step(5'($urandom) & 5'b10111, 1'($urandom_range(0, 15) == 0), 1'b1,
           8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)));

    // random mix, including durations changing while running
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] st;
      for (int i = 0; i < 5; i++) st[i] = ($urandom_range(0, 15) == 0);
      step(st, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12)),
           ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12)));
      if (k == 1500) do_reset(3);
    end

    repeat (3) @(posedge clk);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mod_148_4_4_timer.md
MOD_148_4_4_TIMER -- requirements
Module: mod_148_4_4_timer

Interface
REQ-001 SHALL have parameter BEACON_TIMER, default 20, beacon_timer duration in bit times.
REQ-002 SHALL have parameter BEACON_DET_TIMER, default 22, beacon_det_timer duration in bit times.
REQ-003 SHALL have parameter INVALID_BEACON_TIMER, default 4000, invalid_beacon_timer duration in bit times (13-bit counter).
REQ-004 SHALL have port clk, input, 1, single block clock.
REQ-005 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port bit_tick, input, 1, one-cycle enable marking one bit time.
REQ-007 SHALL have port plca_to_timer, input, 8, to_timer duration in bit times, sampled on start.
REQ-008 SHALL have port plca_burst_timer, input, 8, burst_timer duration in bit times, sampled on start.
REQ-009 SHALL have ports to_timer_start, to_timer_stop, beacon_timer_start, beacon_det_timer_start, invalid_beacon_timer_start, burst_timer_start, input, 1 each, single-cycle command pulses from the PLCA control state diagram.
REQ-010 SHALL have ports to_timer_done, to_timer_not_done, beacon_timer_done, beacon_det_timer_done, beacon_det_timer_not_done, invalid_beacon_timer_done, burst_timer_done, output, 1 each, registered timer status.

Function
REQ-011 SHALL implement five independent down-counting timers: to, beacon, beacon_det, invalid_beacon, burst; each has states IDLE, RUNNING, EXPIRED.
REQ-012 Start pulse in cycle N SHALL load counter with duration and enter RUNNING; from cycle N+1: done=0, not_done=1 (where provided).
REQ-013 bit_tick in the same cycle as start SHALL be ignored by that timer.
REQ-014 In RUNNING, each cycle with bit_tick=1 SHALL decrement counter by 1; cycles with bit_tick=0 hold count.
REQ-015 Decrement to 0 SHALL move to EXPIRED at that edge: done=1, not_done=0 from next cycle.
REQ-016 EXPIRED SHALL persist (done held 1) until next start, stop or reset.
REQ-017 Duration 0 on start SHALL enter EXPIRED directly: done=1 in cycle N+1, no tick required.
REQ-018 Start while RUNNING or EXPIRED SHALL restart: reload, RUNNING, done cleared in N+1.
REQ-019 to_timer_stop SHALL return to_timer to IDLE: done=0, not_done=0 next cycle; stop with no timer running has no effect.
REQ-020 to_timer_start and to_timer_stop in same cycle: start SHALL win.
REQ-021 In IDLE all done and not_done outputs SHALL be 0.
REQ-022 plca_to_timer/plca_burst_timer changes during RUNNING SHALL NOT affect the running count.
REQ-023 Counters SHALL be sized to the maximum duration (8-bit for to/burst, 5-bit beacon/beacon_det, 13-bit invalid_beacon) and SHALL never wrap below 0.
REQ-024 Simultaneous starts on different timers SHALL all take effect in the same cycle.

Reset
REQ-025 reset_n=0 SHALL asynchronously force every timer to IDLE, every counter to 0, and every output to 0.
REQ-026 Reset deassertion mid-operation SHALL leave all timers IDLE; pre-reset starts are lost.
REQ-027 First start is accepted on the first clk edge after reset_n rises.

Verification
REQ-028 plca_to_timer=32, to_timer_start pulse, bit_tick every cycle -> to_timer_not_done=1 for 32 cycles, to_timer_done=1 on cycle 33 after start and held.
REQ-029 beacon_timer_start, bit_tick every 4th cycle -> beacon_timer_done rises after exactly 20 ticks (about 80 cycles), not earlier.
REQ-030 to_timer running at count 10, to_timer_stop -> next cycle to_timer_done=0, to_timer_not_done=0; later ticks no effect.
REQ-031 plca_burst_timer=0, burst_timer_start -> burst_timer_done=1 in next cycle; restart with 5 -> done=0, then 1 after 5 ticks.
REQ-032 invalid_beacon_timer running 3000 ticks, reset_n pulsed low -> all outputs 0 immediately; invalid_beacon_timer_done never asserts without new start.
REQ-033 to_timer_start and to_timer_stop same cycle, plca_to_timer=8 -> not_done=1 next cycle, done=1 after 8 ticks.
